// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_ctrl_pkg
//  Description : Shared constants, FSM state encoding and request/response
//                bundles for the 16-bit single-port RAM controller.
//  Options     : RAM_CTRL_WRITE_VERIFY_EN enables the write read-back states
//                in ram_16bit_ctrl. The encoding always reserves them.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

    localparam int c_ADDR_W = 18;
    localparam int c_DATA_W = 16;

    // Explicit 3-bit encoding. WV_* are only reachable in verify builds.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        WV_ADDR = 3'd4,
        WV_DATA = 3'd5,
        RESP    = 3'd6
    } state_t;

    // Core-side request bundle, sized to the package defaults.
    typedef struct packed {
        logic                write;
        logic [c_ADDR_W-1:0] addr;
        logic [c_DATA_W-1:0] wdata;
    } req_t;

    // Core-side response bundle.
    typedef struct packed {
        logic                write;
        logic [c_DATA_W-1:0] rdata;
    } resp_t;

endpackage : ram_ctrl_pkg
`default_nettype wire

// File: rtl/ram_bus_iobuf.sv
`default_nettype none
// ============================================================================
//  Module      : ram_bus_iobuf
//  Description : Tri-state front end for the shared RAM data bus. Holds the
//                registered write word and drive enable, and exposes the bus
//                as a plain input for the sampling path.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_bus_iobuf #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive_set,
    input  logic              i_drive_clr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    inout  wire  [DATA_W-1:0] io_mem_data
);

    logic              r_drive_en;
    logic [DATA_W-1:0] r_wdata;

    // Drive enable and write word are registered on the same edge as mem_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drive_en <= 1'b0;
            r_wdata    <= '0;
        end else if (i_drive_set) begin
            r_drive_en <= 1'b1;
            r_wdata    <= i_wdata;
        end else if (i_drive_clr) begin
            r_drive_en <= 1'b0;
        end
    end

    assign io_mem_data = r_drive_en ? r_wdata : {DATA_W{1'bz}};
    assign o_rdata     = io_mem_data;

endmodule : ram_bus_iobuf
`default_nettype wire

// File: rtl/ram_16bit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_16bit_ctrl
//  Description : Bus-master controller for an external single-port 16-bit
//                RAM with registered read data. Accepts one request at a time
//                on a valid/ready port, sequences RAM timing, owns the bus
//                direction and returns read data / write completion.
//  Options     : RAM_CTRL_WRITE_VERIFY_EN - read back every write, flag a
//                mismatch on the sticky err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_16bit_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_write,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    inout  wire  [DATA_W-1:0] mem_data
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_mem_we;
    logic              w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    resp_t             r_resp;
    resp_t             w_resp_nxt;
    logic              r_resp_valid;
    logic              w_resp_valid_nxt;
    logic              w_drive_set;
    logic              w_drive_clr;
    logic [DATA_W-1:0] w_sample;
    req_t              w_req;

`ifdef RAM_CTRL_WRITE_VERIFY_EN
    logic              r_err;
    logic              w_err_set;
    logic [DATA_W-1:0] r_wv_wdata;
`endif

    assign w_req = '{write: req_write, addr: req_addr, wdata: req_wdata};

    ram_bus_iobuf #(
        .DATA_W (DATA_W)
    ) u_iobuf (
        .clk         (clk),
        .rst         (rst),
        .i_drive_set (w_drive_set),
        .i_drive_clr (w_drive_clr),
        .i_wdata     (w_req.wdata),
        .o_rdata     (w_sample),
        .io_mem_data (mem_data)
    );

    // Next-state and next-output decode; drive set/clear mirror mem_we edges.
    always_comb begin
        w_state_nxt      = r_state;
        w_mem_we_nxt     = r_mem_we;
        w_mem_addr_nxt   = r_mem_addr;
        w_resp_nxt       = r_resp;
        w_resp_valid_nxt = r_resp_valid;
        w_drive_set      = 1'b0;
        w_drive_clr      = 1'b0;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
        w_err_set        = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_mem_addr_nxt = w_req.addr;
                    if (w_req.write) begin
                        w_mem_we_nxt = 1'b1;
                        w_drive_set  = 1'b1;
                        w_state_nxt  = WR;
                    end else begin
                        w_state_nxt  = RD_ADDR;
                    end
                end
            end
            WR: begin
                w_mem_we_nxt = 1'b0;
                w_drive_clr  = 1'b1;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
                w_state_nxt  = WV_ADDR;
`else
                w_resp_nxt       = '{write: 1'b1, rdata: '0};
                w_resp_valid_nxt = 1'b1;
                w_state_nxt      = RESP;
`endif
            end
            RD_ADDR: begin
                w_state_nxt = RD_DATA;
            end
            RD_DATA: begin
                w_resp_nxt       = '{write: 1'b0, rdata: w_sample};
                w_resp_valid_nxt = 1'b1;
                w_state_nxt      = RESP;
            end
`ifdef RAM_CTRL_WRITE_VERIFY_EN
            WV_ADDR: begin
                w_state_nxt = WV_DATA;
            end
            WV_DATA: begin
                w_resp_nxt       = '{write: 1'b1, rdata: w_sample};
                w_resp_valid_nxt = 1'b1;
                w_err_set        = (w_sample != r_wv_wdata);
                w_state_nxt      = RESP;
            end
`endif
            RESP: begin
                if (resp_ready) begin
                    w_resp_valid_nxt = 1'b0;
                    w_state_nxt      = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered RAM/response outputs; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_resp       <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_resp       <= w_resp_nxt;
            r_resp_valid <= w_resp_valid_nxt;
        end
    end

`ifdef RAM_CTRL_WRITE_VERIFY_EN
    // Keep the written word for comparison; err stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wv_wdata <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_drive_set) begin
                r_wv_wdata <= w_req.wdata;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign req_ready  = (r_state == IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_write = r_resp.write;
    assign resp_rdata = r_resp.rdata;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;

endmodule : ram_16bit_ctrl
`default_nettype wire
